// File: rtl/seq_div_pkg.sv
// seq_div_pkg: shared definitions for the sequential unsigned divider.
//   - state encodings (IDLE/CALC/DONE) and the FSM state type
//   - cnt_w(): width of the step counter that must hold the value N
package seq_div_pkg;

    localparam logic [1:0] S_IDLE = 2'd0;
    localparam logic [1:0] S_CALC = 2'd1;
    localparam logic [1:0] S_DONE = 2'd2;

    typedef enum logic [1:0] {
        IDLE = S_IDLE,
        CALC = S_CALC,
        DONE = S_DONE
    } state_t;

    // Counter is loaded with N, so it needs clog2(N+1) bits.
    function automatic int cnt_w(input int n);
        return $clog2(n + 1);
    endfunction

endpackage

// File: rtl/div_step_usign.sv
// div_step_usign: one combinational restoring-division step.
// Ports:
//   rem      in  M+1  current partial remainder
//   q_msb    in  1    next dividend bit shifted in (MSB of quotient register)
//   b        in  M    divisor
//   rem_next out M+1  partial remainder after this step
//   qbit     out 1    quotient bit produced by this step
module div_step_usign #(
    parameter int M = 11
) (
    input  logic [M:0]   rem,
    input  logic         q_msb,
    input  logic [M-1:0] b,
    output logic [M:0]   rem_next,
    output logic         qbit
);

    logic [M:0]   rs;
    logic [M+1:0] diff;
    // rem < B always holds between steps, so its top bit is shifted out
    // without ever carrying information.
    logic         unused_rem_msb;

    assign unused_rem_msb = rem[M];
    assign rs             = {rem[M-1:0], q_msb};
    // One extra bit on the subtraction exposes the borrow.
    assign diff           = {1'b0, rs} - {2'b00, b};
    assign qbit           = ~diff[M+1];
    assign rem_next       = qbit ? diff[M:0] : rs;

endmodule

// File: rtl/seq_div_usign.sv
// seq_div_usign: sequential unsigned restoring divider, one quotient bit
// per clock, valid/ready on both sides. A = Q*B + R, R < B.
// Ports:
//   clk, rst_n          clock (rising edge), async active-low reset
//   in_valid/in_ready   operand handshake (A: N bits, B: M bits)
//   out_valid/out_ready result handshake (Q: N bits, R: M bits, dbz)
// Optional macro SEQ_DIV_FAST_EXIT_EN: when defined, B==0 or A<B skip the
// iterative phase and complete one edge after accept with identical results.
module seq_div_usign
    import seq_div_pkg::*;
#(
    parameter int N = 32,
    parameter int M = 11
) (
    input  logic         clk,
    input  logic         rst_n,
    input  logic         in_valid,
    output logic         in_ready,
    input  logic [N-1:0] A,
    input  logic [M-1:0] B,
    output logic         out_valid,
    input  logic         out_ready,
    output logic [N-1:0] Q,
    output logic [M-1:0] R,
    output logic         dbz
);

    localparam int CW = cnt_w(N);

    state_t        state, state_nx;
    logic [N-1:0]  q;
    logic [M-1:0]  b_r;
    logic [M:0]    rem;
    logic [CW-1:0] cnt;
    logic          dbz_r;

    logic [M:0]    rem_nx;
    logic          qbit;
    logic          accept;
    logic          fast;

    div_step_usign #(.M(M)) u_step (
        .rem      (rem),
        .q_msb    (q[N-1]),
        .b        (b_r),
        .rem_next (rem_nx),
        .qbit     (qbit)
    );

    assign accept = in_valid && (state == IDLE);

`ifdef SEQ_DIV_FAST_EXIT_EN
    // Results for these cases are known up front; no need to iterate.
    assign fast = (B == '0) || (A < N'(B));
`else
    assign fast = 1'b0;
`endif

    always_comb begin
        state_nx  = state;
        in_ready  = 1'b0;
        out_valid = 1'b0;
        case (state)
            IDLE: begin
                in_ready = 1'b1;
                if (in_valid) state_nx = fast ? DONE : CALC;
            end
            CALC: begin
                if (cnt == CW'(1)) state_nx = DONE;
            end
            DONE: begin
                out_valid = 1'b1;
                if (out_ready) state_nx = IDLE;
            end
            default: state_nx = IDLE;
        endcase
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) state <= IDLE;
        else        state <= state_nx;
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            q     <= '0;
            b_r   <= '0;
            rem   <= '0;
            cnt   <= '0;
            dbz_r <= 1'b0;
        end else if (accept) begin
            b_r   <= B;
            dbz_r <= (B == '0);
            cnt   <= CW'(N);
            if (fast) begin
                // B==0: every subtraction of zero succeeds -> all ones.
                // A<B: quotient is zero and A itself is the remainder.
                q   <= (B == '0) ? '1 : '0;
                rem <= {1'b0, A[M-1:0]};
            end else begin
                q   <= A;
                rem <= '0;
            end
        end else if (state == CALC) begin
            rem <= rem_nx;
            q   <= {q[N-2:0], qbit};
            cnt <= cnt - CW'(1);
        end
    end

    assign Q   = q;
    assign R   = rem[M-1:0];
    assign dbz = dbz_r;

endmodule

// File: tb/tb_seq_div_usign.sv
module tb_seq_div_usign;

    localparam int N = 32;
    localparam int M = 11;
`ifdef SEQ_DIV_FAST_EXIT_EN
    localparam int FLAT = 1;
`else
    localparam int FLAT = N + 1;
`endif
    localparam int SLAT = N + 1;

    logic         clk = 1'b0;
    logic         rst_n = 1'b0;
    logic         in_valid = 1'b0;
    logic         in_ready;
    logic [N-1:0] A = '0;
    logic [M-1:0] B = '0;
    logic         out_valid;
    logic         out_ready = 1'b1;
    logic [N-1:0] Q;
    logic [M-1:0] R;
    logic         dbz;

    int n_cmp = 0;
    int n_err = 0;

    always #5 clk = ~clk;

    seq_div_usign #(.N(N), .M(M)) dut (
        .clk       (clk),
        .rst_n     (rst_n),
        .in_valid  (in_valid),
        .in_ready  (in_ready),
        .A         (A),
        .B         (B),
        .out_valid (out_valid),
        .out_ready (out_ready),
        .Q         (Q),
        .R         (R),
        .dbz       (dbz)
    );

    typedef struct {
        logic [N-1:0] a;
        logic [M-1:0] b;
        logic [N-1:0] q;
        logic [M-1:0] r;
        logic         dbz;
        int           lat;
    } vec_t;

    task automatic chk(input string name, input logic [63:0] act, input logic [63:0] exp);
        n_cmp++;
        if (act !== exp) begin
            n_err++;
            $display("FAIL %s: got 0x%0h, expected 0x%0h", name, act, exp);
        end
    endtask

    // Issue one operation; returns the number of rising edges from the
    // accepting edge (counted as 1) until out_valid is seen. Leaves the
    // bench at the negedge where out_valid was first observed.
    task automatic run_op(input logic [N-1:0] a, input logic [M-1:0] b, output int lat);
        int edges;
        @(negedge clk);
        chk("in_ready_before_accept", 64'(in_ready), 64'd1);
        A = a;
        B = b;
        in_valid = 1'b1;
        @(posedge clk);
        edges = 1;
        @(negedge clk);
        in_valid = 1'b0;
        A = '0;
        B = '0;
        while (!out_valid && edges < 200) begin
            @(posedge clk);
            edges++;
            @(negedge clk);
        end
        if (!out_valid) begin
            n_cmp++;
            n_err++;
            $display("FAIL timeout: out_valid not seen after %0d edges, expected 1", edges);
        end
        lat = edges;
    endtask

    vec_t vecs[$];

    initial begin
        int lat;
        logic [N-1:0] sq;
        logic [M-1:0] sr;
        logic [N-1:0] ra;
        logic [M-1:0] rb;

        vecs.push_back('{32'd100,        11'd7,     32'd14,         11'd2,     1'b0, SLAT});
        vecs.push_back('{32'hFFFF_FFFF,  11'h7FF,   32'h0020_0400,  11'h3FF,   1'b0, SLAT});
        vecs.push_back('{32'h1234,       11'd0,     32'hFFFF_FFFF,  11'h234,   1'b1, FLAT});
        vecs.push_back('{32'd5,          11'd9,     32'd0,          11'd5,     1'b0, FLAT});
        vecs.push_back('{32'd0,          11'd5,     32'd0,          11'd0,     1'b0, FLAT});
        vecs.push_back('{32'd1000,       11'd3,     32'd333,        11'd1,     1'b0, SLAT});
        vecs.push_back('{32'hDEAD_BEEF,  11'd1,     32'hDEAD_BEEF,  11'd0,     1'b0, SLAT});
        vecs.push_back('{32'd12345,      11'd2047,  32'd6,          11'd63,    1'b0, SLAT});
        vecs.push_back('{32'd2047,       11'd2047,  32'd1,          11'd0,     1'b0, SLAT});
        vecs.push_back('{32'd2046,       11'd2047,  32'd0,          11'd2046,  1'b0, FLAT});
        vecs.push_back('{32'd0,          11'd0,     32'hFFFF_FFFF,  11'd0,     1'b1, FLAT});

        // Reset state
        #12;
        chk("rst_in_ready",  64'(in_ready),  64'd1);
        chk("rst_out_valid", 64'(out_valid), 64'd0);
        chk("rst_Q",         64'(Q),         64'd0);
        chk("rst_R",         64'(R),         64'd0);
        chk("rst_dbz",       64'(dbz),       64'd0);
        @(negedge clk);
        rst_n = 1'b1;

        // Directed table
        out_ready = 1'b1;
        foreach (vecs[i]) begin
            run_op(vecs[i].a, vecs[i].b, lat);
            chk($sformatf("v%0d_Q", i),   64'(Q),   64'(vecs[i].q));
            chk($sformatf("v%0d_R", i),   64'(R),   64'(vecs[i].r));
            chk($sformatf("v%0d_dbz", i), 64'(dbz), 64'(vecs[i].dbz));
            chk($sformatf("v%0d_lat", i), 64'(lat), 64'(vecs[i].lat));
            if (!vecs[i].dbz)
                chk($sformatf("v%0d_ident", i), 64'(Q) * 64'(vecs[i].b) + 64'(R), 64'(vecs[i].a));
            @(negedge clk);
            chk($sformatf("v%0d_ov_one_cycle", i), 64'(out_valid), 64'd0);
        end

        // Backpressure: hold result in DONE, stray in_valid must be ignored
        out_ready = 1'b0;
        run_op(32'd100, 11'd7, lat);
        for (int k = 0; k < 10; k++) begin
            A = 32'(k * 37 + 1);
            B = 11'(k + 2);
            in_valid = k[0];
            @(negedge clk);
            chk("bp_out_valid", 64'(out_valid), 64'd1);
            chk("bp_in_ready",  64'(in_ready),  64'd0);
            chk("bp_Q",         64'(Q),         64'd14);
            chk("bp_R",         64'(R),         64'd2);
            chk("bp_dbz",       64'(dbz),       64'd0);
        end
        in_valid = 1'b0;
        out_ready = 1'b1;
        @(negedge clk);
        chk("bp_release_in_ready",  64'(in_ready),  64'd1);
        chk("bp_release_out_valid", 64'(out_valid), 64'd0);

        // Reset in the middle of CALC
        @(negedge clk);
        A = 32'd1000;
        B = 11'd3;
        in_valid = 1'b1;
        @(negedge clk);
        in_valid = 1'b0;
        repeat (10) @(posedge clk);
        #2;
        rst_n = 1'b0;
        #1;
        chk("mrst_in_ready",  64'(in_ready),  64'd1);
        chk("mrst_out_valid", 64'(out_valid), 64'd0);
        chk("mrst_Q",         64'(Q),         64'd0);
        chk("mrst_R",         64'(R),         64'd0);
        chk("mrst_dbz",       64'(dbz),       64'd0);
        // no result may appear while reset is held
        repeat (40) begin
            @(negedge clk);
            if (out_valid) chk("mrst_no_ov", 64'(out_valid), 64'd0);
        end
        rst_n = 1'b1;
        run_op(32'd1000, 11'd3, lat);
        chk("mrst_rerun_Q",   64'(Q),   64'd333);
        chk("mrst_rerun_R",   64'(R),   64'd1);
        chk("mrst_rerun_lat", 64'(lat), 64'(SLAT));
        @(negedge clk);

        // Random pairs with biased corners
        for (int t = 0; t < 300; t++) begin
            ra = $urandom;
            case (t % 6)
                0: rb = 11'd1;
                1: rb = 11'h7FF;
                2: rb = 11'd0;
                default: rb = 11'($urandom_range(1, 2047));
            endcase
            if (t % 7 == 3 && rb != 0) ra = 32'($urandom_range(0, int'(rb) - 1));
            run_op(ra, rb, lat);
            sq = Q;
            sr = R;
            if (rb == 0) begin
                chk("rnd_dbz_Q",   64'(sq),  64'hFFFF_FFFF);
                chk("rnd_dbz_R",   64'(sr),  64'(ra[M-1:0]));
                chk("rnd_dbz_flag", 64'(dbz), 64'd1);
            end else begin
                chk("rnd_ident", 64'(sq) * 64'(rb) + 64'(sr), 64'(ra));
                chk("rnd_r_lt_b", 64'(sr < rb), 64'd1);
                chk("rnd_q", 64'(sq), 64'(ra / 32'(rb)));
                chk("rnd_flag", 64'(dbz), 64'd0);
            end
            chk("rnd_lat", 64'(lat), 64'((rb == 0 || ra < 32'(rb)) ? FLAT : SLAT));
        end

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
        $finish;
    end

endmodule
